// File: rtl/pc_fetch.sv
// rtl/pc_fetch.sv - instruction-fetch stage: program counter, single-outstanding imem read, decode buffer
// Optional feature macro: BRANCH_ALIGN_CHK_EN (reject misaligned redirect targets and pulse fetch_misalign_o)
module pc_fetch #(
  parameter int unsigned      XLEN      = 32,
  parameter logic [XLEN-1:0]  RESET_PC  = '0,
  parameter logic [31:0]      NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            branch_i,
  input  logic [XLEN-1:0] branch_target_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_rvalid_i,
  input  logic [31:0]     imem_rdata_i,
  output logic            instr_valid_o,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] instr_pc_o,
  input  logic            instr_ready_i,
  output logic            fetch_misalign_o
);

  typedef enum logic [2:0] {
    S_RESET = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_FULL  = 3'd3,
    S_KILL  = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            req_q, req_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            valid_q, valid_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] ipc_q, ipc_d;
  logic            misalign_q, misalign_d;

  logic            redirect;
  logic [XLEN-1:0] target;

`ifdef BRANCH_ALIGN_CHK_EN
  // A misaligned target is refused outright: the branch is treated as if it never happened.
  logic misaligned;
  assign misaligned = branch_i & (branch_target_i[1:0] != 2'b00);
  assign redirect   = branch_i & ~misaligned;
  assign target     = branch_target_i;
  assign misalign_d = misaligned;
`else
  // Without the check the low target bits are simply dropped to keep the PC word aligned.
  assign redirect   = branch_i;
  assign target     = branch_target_i & {{(XLEN-2){1'b1}}, 2'b00};
  assign misalign_d = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a redirect overrides every other event in the same cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: state_d = redirect ? S_KILL : S_WAIT;
      S_WAIT: begin
        if (redirect)           state_d = imem_rvalid_i ? S_FETCH : S_KILL;
        else if (imem_rvalid_i) state_d = S_FULL;
      end
      S_FULL: begin
        if (redirect || instr_ready_i) state_d = S_FETCH;
      end
      S_KILL: begin
        if (imem_rvalid_i) state_d = S_FETCH;
      end
      default: state_d = S_RESET;
    endcase
  end

  // Output / datapath next values; the request is raised on entry to FETCH so it lasts exactly that cycle
  always_comb begin
    pc_d    = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    if (redirect) begin
      pc_d    = target;
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end else if (state_q == S_WAIT && imem_rvalid_i) begin
      instr_d = imem_rdata_i;
      ipc_d   = pc_q;
      valid_d = 1'b1;
      pc_d    = pc_q + XLEN'(4);
    end else if (state_q == S_FULL && instr_ready_i) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end
    req_d  = (state_d == S_FETCH);
    addr_d = req_d ? pc_d : addr_q;
  end

  // Datapath and output registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pc_q       <= RESET_PC;
      req_q      <= 1'b0;
      addr_q     <= RESET_PC;
      valid_q    <= 1'b0;
      instr_q    <= NOP_INSTR;
      ipc_q      <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      ipc_q      <= ipc_d;
      misalign_q <= misalign_d;
    end
  end

  assign imem_req_o       = req_q;
  assign imem_addr_o      = addr_q;
  assign instr_valid_o    = valid_q;
  assign instr_o          = instr_q;
  assign instr_pc_o       = ipc_q;
  assign fetch_misalign_o = misalign_q;

endmodule

// File: tb/tb_pc_fetch.sv
// tb/tb_pc_fetch.sv - directed self-checking bench for pc_fetch
module tb_pc_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;

  logic        branch, rvalid, ready;
  logic [31:0] target, rdata;
  logic        req, valid, misalign;
  logic [31:0] addr, instr, ipc;

  logic        branch2, rvalid2, ready2;
  logic [31:0] target2, rdata2;
  logic        req2, valid2, misalign2;
  logic [31:0] addr2, instr2, ipc2;

  int checks = 0;
  int errors = 0;

  pc_fetch dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .branch_i(branch), .branch_target_i(target),
    .imem_req_o(req), .imem_addr_o(addr),
    .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
    .instr_valid_o(valid), .instr_o(instr), .instr_pc_o(ipc),
    .instr_ready_i(ready), .fetch_misalign_o(misalign)
  );

  pc_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk_i(clk), .rst_n_i(rst_n),
    .branch_i(branch2), .branch_target_i(target2),
    .imem_req_o(req2), .imem_addr_o(addr2),
    .imem_rvalid_i(rvalid2), .imem_rdata_i(rdata2),
    .instr_valid_o(valid2), .instr_o(instr2), .instr_pc_o(ipc2),
    .instr_ready_i(ready2), .fetch_misalign_o(misalign2)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Caller is in FETCH with the request for a_exp visible; completes one latency-1 read.
  task automatic fetch_one(input string tag, input logic [31:0] a_exp, input logic [31:0] d);
    chk({tag, " req"}, {31'b0, req}, 32'd1);
    chk({tag, " addr"}, addr, a_exp);
    step();
    chk({tag, " req drop"}, {31'b0, req}, 32'd0);
    rvalid = 1'b1; rdata = d;
    step();
    rvalid = 1'b0;
    chk({tag, " valid"}, {31'b0, valid}, 32'd1);
    chk({tag, " instr"}, instr, d);
    chk({tag, " pc"}, ipc, a_exp);
  endtask

  initial begin
    branch = 0; rvalid = 0; ready = 0; target = '0; rdata = '0;
    branch2 = 0; rvalid2 = 0; ready2 = 0; target2 = '0; rdata2 = '0;
    #2 rst_n = 1'b0;
    step(); step();

    chk("rst req", {31'b0, req}, 32'd0);
    chk("rst addr", addr, 32'h0);
    chk("rst valid", {31'b0, valid}, 32'd0);
    chk("rst instr", instr, NOP);
    chk("rst pc", ipc, 32'h0);
    chk("rst misalign", {31'b0, misalign}, 32'd0);

    // Test 1: 3-cycle cadence with ready held high
    rst_n = 1'b1;
    ready = 1'b1;
    step();
    fetch_one("t1a", 32'h0, 32'hA000_0000);
    step();
    chk("t1a consumed", {31'b0, valid}, 32'd0);
    chk("t1a nop", instr, NOP);
    fetch_one("t1b", 32'h4, 32'hA000_0004);
    step();

    // Test 2: decode stalls 5 cycles in FULL
    ready = 1'b0;
    fetch_one("t2", 32'h8, 32'hA000_0008);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t2 hold valid", {31'b0, valid}, 32'd1);
      chk("t2 hold instr", instr, 32'hA000_0008);
      chk("t2 hold pc", ipc, 32'h8);
      chk("t2 no req", {31'b0, req}, 32'd0);
    end
    ready = 1'b1;
    step();
    ready = 1'b0;
    chk("t2 released", {31'b0, valid}, 32'd0);
    chk("t2 next addr", addr, 32'hC);

    // Test 3: redirect in WAIT without rvalid -> KILL, stale data dropped
    step();
    branch = 1'b1; target = 32'h100;
    step();
    branch = 1'b0;
    chk("t3 kill valid", {31'b0, valid}, 32'd0);
    chk("t3 kill req", {31'b0, req}, 32'd0);
    step();
    chk("t3 kill wait req", {31'b0, req}, 32'd0);
    rvalid = 1'b1; rdata = 32'hDEAD_DEAD;
    step();
    rvalid = 1'b0;
    chk("t3 discard valid", {31'b0, valid}, 32'd0);
    chk("t3 discard instr", instr, NOP);
    chk("t3 req", {31'b0, req}, 32'd1);
    chk("t3 addr", addr, 32'h100);

    // Test 4: redirect coincident with rvalid in WAIT
    step();
    rvalid = 1'b1; rdata = 32'hBEEF_BEEF; branch = 1'b1; target = 32'h200;
    step();
    rvalid = 1'b0; branch = 1'b0;
    chk("t4 valid", {31'b0, valid}, 32'd0);
    chk("t4 instr", instr, NOP);
    fetch_one("t4 refetch", 32'h200, 32'hB000_0200);

    // Redirect together with ready in FULL: flushed, refetch from target
    ready = 1'b1; branch = 1'b1; target = 32'h300;
    step();
    ready = 1'b0; branch = 1'b0;
    chk("flush valid", {31'b0, valid}, 32'd0);
    chk("flush addr", addr, 32'h300);

    // Redirect while the request is on the bus -> KILL
    branch = 1'b1; target = 32'h400;
    step();
    branch = 1'b0;
    chk("fetch kill req", {31'b0, req}, 32'd0);
    rvalid = 1'b1; rdata = 32'h1234_5678;
    step();
    rvalid = 1'b0;
    chk("fetch kill valid", {31'b0, valid}, 32'd0);
    chk("fetch kill addr", addr, 32'h400);

    // Test 6: misaligned target 0x102 in WAIT
    step();
    branch = 1'b1; target = 32'h102;
    step();
    branch = 1'b0;
`ifdef BRANCH_ALIGN_CHK_EN
    chk("t6 misalign pulse", {31'b0, misalign}, 32'd1);
    rvalid = 1'b1; rdata = 32'hC000_0400;
    step();
    rvalid = 1'b0;
    chk("t6 misalign end", {31'b0, misalign}, 32'd0);
    chk("t6 valid", {31'b0, valid}, 32'd1);
    chk("t6 pc kept", ipc, 32'h400);
    ready = 1'b1;
    step();
    ready = 1'b0;
    chk("t6 next addr", addr, 32'h404);
`else
    chk("t6 misalign tied", {31'b0, misalign}, 32'd0);
    chk("t6 kill req", {31'b0, req}, 32'd0);
    rvalid = 1'b1; rdata = 32'hC000_0400;
    step();
    rvalid = 1'b0;
    chk("t6 valid", {31'b0, valid}, 32'd0);
    chk("t6 aligned addr", addr, 32'h100);
`endif

    // Asynchronous reset while a request is outstanding
    step();
    rst_n = 1'b0;
    #1;
    chk("async rst req", {31'b0, req}, 32'd0);
    chk("async rst addr", addr, 32'h0);
    chk("async rst valid", {31'b0, valid}, 32'd0);
    step();

    // Test 5: PC wrap from RESET_PC = 0xFFFFFFFC
    rst_n = 1'b1;
    step();
    chk("t5 req", {31'b0, req2}, 32'd1);
    chk("t5 addr", addr2, 32'hFFFF_FFFC);
    step();
    rvalid2 = 1'b1; rdata2 = 32'hD000_0001;
    step();
    rvalid2 = 1'b0;
    chk("t5 valid", {31'b0, valid2}, 32'd1);
    chk("t5 pc", ipc2, 32'hFFFF_FFFC);
    chk("t5 instr", instr2, 32'hD000_0001);
    ready2 = 1'b1;
    step();
    ready2 = 1'b0;
    chk("t5 wrap req", {31'b0, req2}, 32'd1);
    chk("t5 wrap addr", addr2, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
